// File: rtl/poly_nco_if.sv
// Bus bundle for poly_nco: sample request, voice configuration, sine ROM port
// and mixed-sample output. The slave modport is the oscillator side.
interface poly_nco_if #(
   parameter int VOICES  = 8,
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 12,
   parameter int OUT_W   = 16
);
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

   logic                sample_tick;
   logic                cfg_we;
   logic [VW-1:0]       cfg_voice;
   logic [1:0]          cfg_sel;
   logic [PHASE_W-1:0]  cfg_data;
   logic [ADDR_W-1:0]   rom_addr;
   logic [OUT_W-1:0]    rom_data;
   logic [OUT_W-1:0]    out;
   logic                out_valid;
   logic                busy;
   logic                overrun;
   logic [1:0]          dbg_state;

   modport master (
      output sample_tick, cfg_we, cfg_voice, cfg_sel, cfg_data, rom_data,
      input  rom_addr, out, out_valid, busy, overrun, dbg_state
   );

   modport slave (
      input  sample_tick, cfg_we, cfg_voice, cfg_sel, cfg_data, rom_data,
      output rom_addr, out, out_valid, busy, overrun, dbg_state
   );
endinterface

// File: rtl/poly_nco.sv
// Time-multiplexed polyphonic NCO: one phase/waveform/multiply datapath swept
// over all voices per sample tick, summed and saturated into one mixed sample.
module poly_nco #(
   parameter int VOICES  = 8,
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 12,
   parameter int OUT_W   = 16
) (
   input  logic      Clk,
   input  logic      Reset,
   poly_nco_if.slave bus
);
   // Handshake: sample_tick is a single-cycle request, accepted only while busy=0
   // (otherwise dropped and overrun latches); out_valid is a one-cycle pulse with
   // no back-pressure, and out holds its value until the next pulse.
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int CW = $clog2(VOICES + 1);
   localparam int AW = OUT_W + VW + 1;

   localparam logic [OUT_W-1:0] MSB_MASK = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] SQ_POS   = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SQ_NEG   = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
   localparam logic [AW-1:0]    ACC_HI   = {{(AW-OUT_W){1'b0}}, SQ_POS};
   localparam logic [AW-1:0]    ACC_LO   = {{(AW-OUT_W){1'b1}}, MSB_MASK};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SWEEP  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   logic [PHASE_W-1:0] r_freq  [VOICES];
   logic [PHASE_W-1:0] r_phase [VOICES];
   logic [OUT_W-1:0]   r_amp   [VOICES];
   logic [1:0]         r_shape [VOICES];
   logic               r_gate  [VOICES];
   logic               r_sync  [VOICES];

   state_t             r_state;
   state_t             w_next;
   logic [CW-1:0]      r_cnt;
   logic [AW-1:0]      r_acc;
   logic [OUT_W-1:0]   r_out;
   logic               r_out_valid;
   logic               r_overrun;

   logic               r_b_valid;
   logic [OUT_W-1:0]   r_b_q;
   logic [OUT_W-1:0]   r_b_amp;
   logic [1:0]         r_b_shape;
   logic               r_b_gate;

   logic               w_busy;
   logic               w_start;
   logic               w_stage_a;
   logic               w_finish;
   logic [VW-1:0]      w_va;
   logic [PHASE_W-1:0] w_phase_rd;
   logic [PHASE_W-1:0] w_phase_nx;
   logic [OUT_W-2:0]   w_tri_u;
   logic [OUT_W-1:0]   w_wave;
   logic [2*OUT_W-1:0] w_amp_x;
   logic [2*OUT_W-1:0] w_wave_x;
   logic [2*OUT_W-1:0] w_prod;
   logic [OUT_W-1:0]   w_term;
   logic [AW-1:0]      w_term_x;
   logic [OUT_W-1:0]   w_sat;
   logic               w_unused;

   always_comb begin
      w_next    = r_state;
      w_busy    = 1'b0;
      w_start   = 1'b0;
      w_stage_a = 1'b0;
      w_finish  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.sample_tick) begin
               w_next  = S_SWEEP;
               w_start = 1'b1;
            end
         end
         S_SWEEP: begin
            w_busy    = 1'b1;
            w_stage_a = (r_cnt < CW'(VOICES));
            if (r_cnt == CW'(VOICES)) w_next = S_FINISH;
         end
         S_FINISH: begin
            w_busy   = 1'b1;
            w_finish = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A pending sync makes this stage A see phase 0, then advance from there.
   assign w_va       = r_cnt[VW-1:0];
   assign w_phase_rd = r_sync[w_va] ? '0 : r_phase[w_va];
   assign w_phase_nx = w_phase_rd + (r_gate[w_va] ? r_freq[w_va] : '0);

   assign w_tri_u = r_b_q[OUT_W-1] ? ~r_b_q[OUT_W-2:0] : r_b_q[OUT_W-2:0];

   always_comb begin
      w_wave = bus.rom_data;
      case (r_b_shape)
         2'd0:    w_wave = bus.rom_data;
         2'd1:    w_wave = r_b_q ^ MSB_MASK;
         2'd2:    w_wave = r_b_q[OUT_W-1] ? SQ_NEG : SQ_POS;
         default: w_wave = {w_tri_u, 1'b0} ^ MSB_MASK;
      endcase
   end

   // Sign-extended operands make the low 2*OUT_W bits of the product signed-correct.
   assign w_amp_x  = {{OUT_W{r_b_amp[OUT_W-1]}}, r_b_amp};
   assign w_wave_x = {{OUT_W{w_wave[OUT_W-1]}}, w_wave};
   assign w_prod   = w_amp_x * w_wave_x;
   assign w_term   = w_prod[2*OUT_W-1 -: OUT_W];
   assign w_term_x = r_b_gate ? {{(AW-OUT_W){w_term[OUT_W-1]}}, w_term} : '0;
   assign w_unused = ^w_prod[OUT_W-1:0];

   always_comb begin
      w_sat = r_acc[OUT_W-1:0];
      if ($signed(r_acc) > $signed(ACC_HI))      w_sat = SQ_POS;
      else if ($signed(r_acc) < $signed(ACC_LO)) w_sat = MSB_MASK;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 0; k < VOICES; k++) begin
            r_freq[k]  <= '0;
            r_phase[k] <= '0;
            r_amp[k]   <= '0;
            r_shape[k] <= '0;
            r_gate[k]  <= 1'b0;
            r_sync[k]  <= 1'b0;
         end
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         r_b_valid   <= 1'b0;
         r_b_q       <= '0;
         r_b_amp     <= '0;
         r_b_shape   <= '0;
         r_b_gate    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_out_valid <= 1'b0;
         r_b_valid   <= w_stage_a;

         if (bus.sample_tick && w_busy) r_overrun <= 1'b1;

         if (w_start) begin
            r_cnt <= '0;
            r_acc <= '0;
         end else if (r_state == S_SWEEP) begin
            r_cnt <= r_cnt + CW'(1);
         end

         if (w_stage_a) begin
            r_phase[w_va] <= w_phase_nx;
            r_sync[w_va]  <= 1'b0;
            r_b_q         <= w_phase_rd[PHASE_W-1 -: OUT_W];
            r_b_amp       <= r_amp[w_va];
            r_b_shape     <= r_shape[w_va];
            r_b_gate      <= r_gate[w_va];
         end

         if (r_b_valid) r_acc <= r_acc + w_term_x;

         if (w_finish) begin
            r_out       <= w_sat;
            r_out_valid <= 1'b1;
         end

         // Placed after stage A so a racing gate-on still leaves sync pending.
         if (bus.cfg_we && (int'(bus.cfg_voice) < VOICES)) begin
            case (bus.cfg_sel)
               2'd0: r_freq[bus.cfg_voice] <= bus.cfg_data;
               2'd1: r_amp[bus.cfg_voice]  <= bus.cfg_data[OUT_W-1:0];
               2'd2: begin
                  r_shape[bus.cfg_voice] <= bus.cfg_data[1:0];
                  r_gate[bus.cfg_voice]  <= bus.cfg_data[2];
                  if (bus.cfg_data[2] && !r_gate[bus.cfg_voice])
                     r_sync[bus.cfg_voice] <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rom_addr  = w_stage_a ? w_phase_rd[PHASE_W-1 -: ADDR_W] : '0;
   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = w_busy;
   assign bus.overrun   = r_overrun;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_poly_nco.sv
// Self-checking bench for poly_nco: directed frames plus randomized voice setups
// scored against a frame-level arithmetic model through an expected queue.
module tb_poly_nco;
   localparam int VOICES  = 4;
   localparam int PHASE_W = 24;
   localparam int ADDR_W  = 12;
   localparam int OUT_W   = 16;
   localparam int LAT     = VOICES + 3;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   cyc   = 0;

   poly_nco_if #(.VOICES(VOICES), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

   poly_nco #(.VOICES(VOICES), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Identity sine ROM with one cycle of read latency.
   always @(posedge Clk) bus.rom_data <= OUT_W'(bus.rom_addr);

   int               checks = 0;
   int               errors = 0;
   logic [OUT_W-1:0] exp_q[$];
   int               exp_cyc_q[$];
   logic [OUT_W-1:0] mon_e;
   int               mon_c;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out=%0h at cycle %0d expected no pulse", bus.out, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            chk("out", 32'(bus.out), 32'(mon_e));
            chk("out_valid_cycle", cyc, mon_c);
         end
      end
   end

   // Reference model: per-voice state and one whole frame computed arithmetically.
   int unsigned m_freq  [VOICES];
   int unsigned m_phase [VOICES];
   int          m_amp   [VOICES];
   int          m_shape [VOICES];
   bit          m_gate  [VOICES];
   bit          m_sync  [VOICES];
   int unsigned m_addr  [VOICES];

   task automatic model_clear();
      for (int v = 0; v < VOICES; v++) begin
         m_freq[v] = 0; m_phase[v] = 0; m_amp[v] = 0;
         m_shape[v] = 0; m_gate[v] = 0; m_sync[v] = 0; m_addr[v] = 0;
      end
   endtask

   task automatic model_write(input int v, input int sel, input logic [PHASE_W-1:0] data);
      case (sel)
         0: m_freq[v] = 32'(data);
         1: m_amp[v]  = int'($signed(data[OUT_W-1:0]));
         2: begin
            m_shape[v] = int'(data[1:0]);
            if (data[2] && !m_gate[v]) m_sync[v] = 1'b1;
            m_gate[v] = data[2];
         end
         default: ;
      endcase
   endtask

   function automatic logic [OUT_W-1:0] model_frame();
      longint      sum = 0;
      longint      wave, term, u;
      int unsigned ph, q;
      for (int v = 0; v < VOICES; v++) begin
         ph = m_sync[v] ? 0 : m_phase[v];
         m_addr[v] = ph >> (PHASE_W - ADDR_W);
         q = ph >> (PHASE_W - OUT_W);
         case (m_shape[v])
            0: wave = longint'(m_addr[v]);
            1: wave = longint'(q) - 32768;
            2: wave = (q >= 32768) ? -32767 : 32767;
            default: begin
               u = (q >= 32768) ? longint'(32767 - (q & 32'h7FFF)) : longint'(q);
               wave = 2 * u - 32768;
            end
         endcase
         term = (longint'(m_amp[v]) * wave) >>> 16;
         if (m_gate[v]) sum += term;
         m_phase[v] = (ph + (m_gate[v] ? m_freq[v] : 0)) & 32'h00FF_FFFF;
         m_sync[v] = 1'b0;
      end
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      return OUT_W'(sum);
   endfunction

   task automatic cfg_write(input int v, input int sel, input logic [PHASE_W-1:0] data);
      @(posedge Clk); #1;
      bus.cfg_we    = 1'b1;
      bus.cfg_voice = 2'(v);
      bus.cfg_sel   = 2'(sel);
      bus.cfg_data  = data;
      @(posedge Clk); #1;
      bus.cfg_we    = 1'b0;
      model_write(v, sel, data);
   endtask

   task automatic frame_expect(input bit use_const, input logic [OUT_W-1:0] cval, output int tc);
      logic [OUT_W-1:0] mval;
      @(posedge Clk); #1;
      mval = model_frame();
      exp_q.push_back(use_const ? cval : mval);
      exp_cyc_q.push_back(cyc + LAT);
      tc = cyc;
      bus.sample_tick = 1'b1;
      @(posedge Clk); #1;
      bus.sample_tick = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin
         @(posedge Clk); #1;
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", bus.busy, exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      model_clear();
      exp_q.delete();
      exp_cyc_q.delete();
   endtask

   task automatic chk_idle_outputs(input string tag, input logic [OUT_W-1:0] exp_out);
      chk({tag, "_out"}, 32'(bus.out), 32'(exp_out));
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_overrun"}, 32'(bus.overrun), 0);
      chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
   endtask

   task automatic setup_square(input int v);
      cfg_write(v, 0, 24'h800000);
      cfg_write(v, 1, 24'h007FFF);
      cfg_write(v, 2, 24'h000006);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tc;
      logic [OUT_W-1:0] saw_seq [4];
      bus.sample_tick = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.cfg_voice   = '0;
      bus.cfg_sel     = '0;
      bus.cfg_data    = '0;
      model_clear();
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      chk_idle_outputs("reset", '0);

      // Single square voice over two frames.
      setup_square(0);
      frame_expect(1, 16'h3FFF, tc); wait_idle();
      frame_expect(1, 16'hC000, tc); wait_idle();

      // All four voices square: positive and negative saturation.
      do_reset();
      for (int v = 0; v < VOICES; v++) setup_square(v);
      frame_expect(1, 16'h7FFF, tc); wait_idle();
      frame_expect(1, 16'h8000, tc); wait_idle();

      // Saw, gate rewrite, then gate off/on resync.
      do_reset();
      saw_seq[0] = 16'hC000; saw_seq[1] = 16'hE000; saw_seq[2] = 16'h0000; saw_seq[3] = 16'h1FFF;
      cfg_write(0, 0, 24'h400000);
      cfg_write(0, 1, 24'h007FFF);
      cfg_write(0, 2, 24'h000005);
      for (int k = 0; k < 4; k++) begin
         frame_expect(1, saw_seq[k], tc); wait_idle();
      end
      cfg_write(0, 2, 24'h000005);
      frame_expect(1, 16'hC000, tc); wait_idle();
      frame_expect(1, 16'hE000, tc); wait_idle();
      cfg_write(0, 2, 24'h000001);
      cfg_write(0, 2, 24'h000005);
      frame_expect(1, 16'hC000, tc); wait_idle();

      // Sine on voice 2 through the identity ROM.
      do_reset();
      cfg_write(2, 0, 24'h001000);
      cfg_write(2, 1, 24'h007FFF);
      cfg_write(2, 2, 24'h000004);
      for (int k = 0; k < 5; k++) begin
         frame_expect(1, OUT_W'((k * 32767) >> 16), tc);
         @(posedge Clk); @(posedge Clk); #1;
         chk("sine_rom_addr", 32'(bus.rom_addr), 32'(k));
         wait_idle();
      end

      // Overrun: dropped tick, sticky flag, tick on the out_valid cycle accepted.
      do_reset();
      setup_square(0);
      frame_expect(1, 16'h3FFF, tc);
      @(posedge Clk); @(posedge Clk); #1;
      bus.sample_tick = 1'b1;
      @(posedge Clk); #1;
      bus.sample_tick = 1'b0;
      for (int n = 0; n < 20 && bus.out_valid !== 1'b1; n++) begin
         @(posedge Clk); #1;
      end
      chk("overrun_set", 32'(bus.overrun), 1);
      chk("tick_on_valid_cycle", cyc, tc + LAT);
      void'(model_frame());
      exp_q.push_back(16'hC000);
      exp_cyc_q.push_back(cyc + LAT);
      bus.sample_tick = 1'b1;
      @(posedge Clk); #1;
      bus.sample_tick = 1'b0;
      chk("tick_accepted_busy", 32'(bus.busy), 1);
      wait_idle();
      chk("overrun_sticky", 32'(bus.overrun), 1);
      do_reset();
      chk("overrun_cleared", 32'(bus.overrun), 0);

      // Reset in the middle of a sweep aborts the frame.
      setup_square(0);
      frame_expect(1, 16'h3FFF, tc); wait_idle();
      @(posedge Clk); #1;
      bus.sample_tick = 1'b1;
      tc = cyc;
      @(posedge Clk); #1;
      bus.sample_tick = 1'b0;
      @(posedge Clk); @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      chk_idle_outputs("midreset", '0);
      Reset = 1'b0;
      model_clear();
      repeat (10) @(posedge Clk);
      #1;
      setup_square(0);
      frame_expect(1, 16'h3FFF, tc); wait_idle();

      // Randomized voice setups against the model.
      do_reset();
      for (int v = 0; v < VOICES; v++) begin
         cfg_write(v, 0, 24'($urandom_range(0, 24'hFFFFFF)));
         cfg_write(v, 1, 24'($urandom));
         cfg_write(v, 2, 24'($urandom_range(0, 7)));
      end
      for (int f = 0; f < 24; f++) begin
         int nw;
         nw = $urandom_range(0, 2);
         for (int w = 0; w < nw; w++)
            cfg_write($urandom_range(0, VOICES - 1), $urandom_range(0, 3), 24'($urandom));
         frame_expect(0, '0, tc);
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge Clk);
         #1;
      end

      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
